// File: rtl/cache_init_ctrl_pkg.sv
// Shared types and geometry helpers for the per-bank init/flush sequencer.
// Helpers mirror the cache line-per-bank and line-select-width macros.
package cache_init_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        IDLE    = 3'd1,
        DRAIN   = 3'd2,
        SWEEP   = 3'd3,
        RESPOND = 3'd4
    } cache_init_state_t;

    typedef enum logic {
        ORIGIN_RESET = 1'b0,
        ORIGIN_FLUSH = 1'b1
    } cache_init_origin_t;

    function automatic int cs_lines_per_bank(input int cache_size, input int line_size,
                                             input int num_banks, input int num_ways);
        return cache_size / (line_size * num_banks * num_ways);
    endfunction

    // A single-line bank still needs a one-bit index.
    function automatic int cs_line_sel_bits(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/cache_init_ctrl_if.sv
// Flush request/response handshake plus the bank-side init strobe and pipeline status.
// master = sequencer side, slave = bank/core side.
interface cache_init_ctrl_if
    import cache_init_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH     = 8,
    parameter int LINE_SEL_BITS = 4
);
    logic                     flush_req_valid;
    logic [TAG_WIDTH-1:0]     flush_req_tag;
    logic                     flush_req_ready;
    logic                     flush_rsp_valid;
    logic [TAG_WIDTH-1:0]     flush_rsp_tag;
    logic                     flush_rsp_ready;
    logic                     pipe_empty;
    logic                     stall;
    logic                     init_valid;
    logic [LINE_SEL_BITS-1:0] init_line;
    logic                     core_req_block;

    modport master (
        input  flush_req_valid, flush_req_tag, flush_rsp_ready, pipe_empty, stall,
        output flush_req_ready, flush_rsp_valid, flush_rsp_tag,
               init_valid, init_line, core_req_block
    );

    modport slave (
        output flush_req_valid, flush_req_tag, flush_rsp_ready, pipe_empty, stall,
        input  flush_req_ready, flush_rsp_valid, flush_rsp_tag,
               init_valid, init_line, core_req_block
    );

endinterface

// File: rtl/cache_init_ctrl.sv
// Sweeps every bank line with an init strobe after reset and per accepted flush; tagged flush response.
// Outputs decode registered state only (init_valid also gated by stall); stall freezes the sweep.
module cache_init_ctrl
    import cache_init_ctrl_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 64,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 1,
    parameter int TAG_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    cache_init_ctrl_if.master  ctrl_if
);

    localparam int LINES         = cs_lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
    localparam int LINE_SEL_BITS = cs_line_sel_bits(LINES);
    localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES - 1);

    cache_init_state_t        state_q,  state_d;
    cache_init_origin_t       origin_q, origin_d;
    logic [LINE_SEL_BITS-1:0] line_q,   line_d;
    logic [TAG_WIDTH-1:0]     tag_q,    tag_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            origin_q <= ORIGIN_RESET;
            line_q   <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        line_d   = line_q;
        tag_d    = tag_q;
        unique case (state_q)
            BOOT: begin
                origin_d = ORIGIN_RESET;
                state_d  = SWEEP;
            end
            IDLE: begin
                if (ctrl_if.flush_req_valid) begin
                    tag_d    = ctrl_if.flush_req_tag;
                    origin_d = ORIGIN_FLUSH;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (ctrl_if.pipe_empty) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                // Wrap on explicit compare so non-power-of-2 line counts work.
                if (!ctrl_if.stall) begin
                    if (line_q == LAST_LINE) begin
                        line_d  = '0;
                        state_d = (origin_q == ORIGIN_FLUSH) ? RESPOND : IDLE;
                    end else begin
                        line_d  = line_q + LINE_SEL_BITS'(1);
                    end
                end
            end
            RESPOND: begin
                if (ctrl_if.flush_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign ctrl_if.flush_req_ready = (state_q == IDLE);
    assign ctrl_if.core_req_block  = (state_q != IDLE);
    assign ctrl_if.init_valid      = (state_q == SWEEP) && !ctrl_if.stall;
    assign ctrl_if.init_line       = line_q;
    assign ctrl_if.flush_rsp_valid = (state_q == RESPOND);
    assign ctrl_if.flush_rsp_tag   = tag_q;

    a_line_in_range: assert property (@(posedge clk) disable iff (reset)
        line_q <= LAST_LINE);

    a_rsp_held: assert property (@(posedge clk) disable iff (reset)
        ctrl_if.flush_rsp_valid && !ctrl_if.flush_rsp_ready
        |=> ctrl_if.flush_rsp_valid && $stable(ctrl_if.flush_rsp_tag));

endmodule

// File: tb/tb_cache_init_ctrl.sv
// Bench for cache_init_ctrl: spec-timed vector table, directed corner sequences, random run vs reference model.
module tb_cache_init_ctrl;
    import cache_init_ctrl_pkg::*;

    localparam int CACHE_SIZE = 4096;
    localparam int LINE_SIZE  = 64;
    localparam int NUM_BANKS  = 1;
    localparam int NUM_WAYS   = 4;
    localparam int TW         = 8;
    localparam int LINES      = 16;
    localparam int LSB        = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_init_ctrl_if #(.TAG_WIDTH(TW), .LINE_SEL_BITS(LSB)) bus ();

    cache_init_ctrl #(
        .CACHE_SIZE(CACHE_SIZE), .LINE_SIZE(LINE_SIZE), .NUM_BANKS(NUM_BANKS),
        .NUM_WAYS(NUM_WAYS), .TAG_WIDTH(TW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus.master)
    );

    typedef struct packed {
        logic          ready;
        logic          iv;
        logic [LSB-1:0] line;
        logic          rv;
        logic [TW-1:0] tag;
        logic          block;
    } out_t;

    typedef struct {
        logic rq; logic [TW-1:0] tg; logic pe; logic st; logic rr;
        out_t exp;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    out_t got;
    vec_t tab[$];

    // Reference model: where in the init/flush lifecycle the bank is.
    bit          m_boot, m_drain, m_rsp, m_from_flush;
    int          m_pos;          // line being swept, -1 when not sweeping
    logic [TW-1:0] m_tag;

    function automatic bit m_idle();
        return !(m_boot || m_drain || (m_pos >= 0) || m_rsp);
    endfunction

    task automatic model_reset();
        m_boot = 1; m_drain = 0; m_rsp = 0; m_from_flush = 0; m_pos = -1; m_tag = '0;
    endtask

    task automatic model_step();
        if (reset) model_reset();
        else if (m_boot) begin m_boot = 0; m_pos = 0; m_from_flush = 0; end
        else if (m_idle()) begin
            if (bus.flush_req_valid) begin
                m_tag = bus.flush_req_tag; m_drain = 1; m_from_flush = 1;
            end
        end
        else if (m_drain) begin
            if (bus.pipe_empty) begin m_drain = 0; m_pos = 0; end
        end
        else if (m_pos >= 0) begin
            if (!bus.stall) begin
                if (m_pos == LINES - 1) begin m_pos = -1; m_rsp = m_from_flush; end
                else m_pos++;
            end
        end
        else if (m_rsp && bus.flush_rsp_ready) m_rsp = 0;
    endtask

    task automatic check_model(input string name);
        out_t e;
        e.ready = m_idle();
        e.block = !m_idle();
        e.iv    = (m_pos >= 0) && !bus.stall;
        e.line  = (m_pos >= 0) ? LSB'(m_pos) : '0;
        e.rv    = m_rsp;
        e.tag   = m_tag;
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: dut outputs %h, model expects %h", name, $time, got, e);
        end
    endtask

    task automatic expect_val(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic tick(input logic rq, input logic [TW-1:0] tg, input logic pe,
                        input logic st, input logic rr, input logic rst, input string name);
        bus.flush_req_valid = rq;
        bus.flush_req_tag   = tg;
        bus.pipe_empty      = pe;
        bus.stall           = st;
        bus.flush_rsp_ready = rr;
        reset               = rst;
        if (rst) model_reset();
        @(negedge clk);
        got = '{ready: bus.flush_req_ready, iv: bus.init_valid, line: bus.init_line,
                rv: bus.flush_rsp_valid, tag: bus.flush_rsp_tag, block: bus.core_req_block};
        check_model(name);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(input logic rq, input logic [TW-1:0] tg, input logic pe, input logic st,
                       input logic rr, input logic e_ready, input logic e_iv, input int e_line,
                       input logic e_rv, input logic [TW-1:0] e_tag, input logic e_block);
        vec_t v;
        v.rq = rq; v.tg = tg; v.pe = pe; v.st = st; v.rr = rr;
        v.exp = '{ready: e_ready, iv: e_iv, line: LSB'(e_line), rv: e_rv, tag: e_tag, block: e_block};
        tab.push_back(v);
    endtask

    initial begin
        int n, first_n, found, acc_n, rv_count;
        int acc_at[2];
        int rsp_at[$];
        logic [TW-1:0] rsp_tags[$];
        int lines_seen[$];
        logic rq;

        // Reset release then flush 0x5A, with rsp_ready held low for 3 response cycles.
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < LINES; i++) add(0, 8'h00, 1, 0, 0, 0, 1, i, 0, 8'h00, 1);
        add(1, 8'h5A, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h5A, 1);
        for (int i = 0; i < LINES; i++) add(0, 8'h00, 1, 0, 0, 0, 1, i, 0, 8'h5A, 1);
        for (int k = 0; k < 4; k++) add(0, 8'h00, 1, 0, (k == 3), 0, 0, 0, 1, 8'h5A, 1);
        add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h5A, 0);

        bus.flush_req_valid = 0; bus.flush_req_tag = '0; bus.pipe_empty = 1;
        bus.stall = 0; bus.flush_rsp_ready = 0; reset = 1;
        model_reset();
        #1;
        tick(0, 8'h00, 1, 0, 0, 1, "reset");
        tick(0, 8'h00, 1, 0, 0, 1, "reset");
        expect_val("reset_block", got.block, 1);

        for (int i = 0; i < tab.size(); i++) begin
            tick(tab[i].rq, tab[i].tg, tab[i].pe, tab[i].st, tab[i].rr, 0, "tbl_model");
            vectors++;
            if (got !== tab[i].exp) begin
                miscompares++;
                $display("FAIL tbl[%0d]: dut outputs %h, expected %h", i, got, tab[i].exp);
            end
        end

        // Drain: pipe_empty low for 5 cycles after accepting 0x11.
        tick(1, 8'h11, 0, 0, 1, 0, "drain_acc");
        for (int i = 0; i < 5; i++) begin
            tick(0, 8'h00, 0, 0, 1, 0, "drain_hold");
            expect_val("drain_iv", got.iv, 0);
        end
        first_n = -1;
        for (int k = 1; k <= 40 && first_n < 0; k++) begin
            tick(0, 8'h00, 1, 0, 1, 0, "drain_run");
            if (got.rv) begin first_n = k; expect_val("drain_tag", got.tag, 8'h11); end
        end
        expect_val("drain_rsp_cycle", first_n, LINES + 2);

        // Two stall cycles at line 7 of flush 0x22.
        tick(1, 8'h22, 1, 0, 1, 0, "stall_acc");
        first_n = -1;
        for (n = 1; n <= 40 && first_n < 0; n++) begin
            tick(0, 8'h00, 1, (n == 9 || n == 10), 1, 0, "stall_run");
            if (n == 9 || n == 10) begin
                expect_val("stall_iv", got.iv, 0);
                expect_val("stall_line", got.line, 7);
            end
            if (got.rv) first_n = n;
        end
        expect_val("stall_rsp_cycle", first_n, LINES + 4);

        // Request held through the post-reset sweep, then back-to-back flushes 0x01, 0x02.
        tick(1, 8'h01, 1, 0, 1, 1, "b2b_reset");
        acc_n = 0; acc_at[0] = -1; acc_at[1] = -1;
        for (int t = 0; t < 80; t++) begin
            rq = (acc_n < 2);
            tick(rq, (acc_n == 0) ? 8'h01 : 8'h02, 1, 0, 1, 0, "b2b_run");
            if (t < LINES + 1) expect_val("b2b_not_ready", got.ready, 0);
            if (got.ready && rq) begin acc_at[acc_n] = t; acc_n++; end
            if (got.rv) begin rsp_at.push_back(t); rsp_tags.push_back(got.tag); end
        end
        expect_val("b2b_acc0", acc_at[0], LINES + 1);
        expect_val("b2b_rsp_count", rsp_tags.size(), 2);
        if (rsp_tags.size() == 2) begin
            expect_val("b2b_tag0", rsp_tags[0], 8'h01);
            expect_val("b2b_tag1", rsp_tags[1], 8'h02);
            expect_val("b2b_rsp0", rsp_at[0], 2 * LINES + 3);
            expect_val("b2b_acc1", acc_at[1], rsp_at[0] + 1);
        end

        // Reset in the middle of flush 0x33 at line 9.
        tick(1, 8'h33, 1, 0, 1, 0, "rst_acc");
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick(0, 8'h00, 1, 0, 1, 0, "rst_run");
            if (got.iv && got.line == 8) found = 1;
        end
        expect_val("rst_find_line8", found, 1);
        tick(0, 8'h00, 1, 0, 1, 1, "rst_mid");
        vectors++;
        if (got !== out_t'{ready: 0, iv: 0, line: 0, rv: 0, tag: 0, block: 1}) begin
            miscompares++;
            $display("FAIL rst_mid_values: dut outputs %h, expected reset values", got);
        end
        rv_count = 0;
        for (int k = 0; k < 40; k++) begin
            tick(0, 8'h00, 1, 0, 1, 0, "rst_after");
            if (got.iv) lines_seen.push_back(int'(got.line));
            if (got.rv) rv_count++;
        end
        expect_val("rst_no_rsp", rv_count, 0);
        expect_val("rst_sweep_len", lines_seen.size(), LINES);
        for (int i = 0; i < lines_seen.size() && i < LINES; i++)
            expect_val("rst_sweep_line", lines_seen[i], i);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(0, 9) < 3), TW'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 2), $urandom_range(0, 1), ($urandom_range(0, 199) == 0),
                 "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
